hazard_unit: RTL

- Decode-stage hazard/sequencing block. Watches the instruction in ID and the destination registers in EX/MEM/WB.
- Drives the decode control unit's stall, ForwardA, ForwardB and Exception inputs, plus PC and IF/ID hold and the ID/EX bubble.
- Owns the two-cycle issue of double-word LDW (opcode 8) and SDW (opcode 9): cycle 1 uses register r, cycle 2 uses r+1.

---
 rtl/hazard_pkg.sv | 42 ++++
 rtl/hazard_unit_fwd_select.sv | 30 +++
 rtl/hazard_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared opcodes, forward-select codes, FSM encoding and source-usage decode
// for the decode-stage hazard unit.
package hazard_pkg;

  localparam int unsigned OP_OR   = 0;
  localparam int unsigned OP_AND  = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_SUB  = 3;
  localparam int unsigned OP_LW   = 4;
  localparam int unsigned OP_ADDI = 5;
  localparam int unsigned OP_ORI  = 6;
  localparam int unsigned OP_SW   = 7;
  localparam int unsigned OP_LDW  = 8;
  localparam int unsigned OP_SDW  = 9;
  localparam int unsigned OP_BEQ  = 10;
  localparam int unsigned OP_BNE  = 11;
  localparam int unsigned OP_BGT  = 12;
  localparam int unsigned OP_JR   = 13;
  localparam int unsigned OP_J    = 14;
  localparam int unsigned OP_CLL  = 15;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    DW2  = 1'b1
  } hazard_state_e;

  function automatic logic uses_src_a(input logic [31:0] op);
    return (op <= OP_SDW) || (op == OP_JR);
  endfunction

  // Stores and compare-branches read their data/compare register from the rd field.
  function automatic logic uses_src_b(input logic [31:0] op);
    return (op <= OP_SUB) || (op == OP_SW) || (op == OP_SDW) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGT);
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Per-source forwarding mux select: youngest writing stage wins, r0 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             regwr_ex,
  input  logic [REG_W-1:0] rd_mem,
  input  logic             regwr_mem,
  input  logic [REG_W-1:0] rd_wb,
  input  logic             regwr_wb,
  output logic [1:0]       fwd
);

  logic live;
  assign live = used && (src != '0);

  always_comb begin
    fwd = FWD_RF;
    if (live) begin
      if (regwr_ex && (rd_ex == src))        fwd = FWD_EX;
      else if (regwr_mem && (rd_mem == src)) fwd = FWD_MEM;
      else if (regwr_wb && (rd_wb == src))   fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard unit: forwarding, load-use stall, LDW/SDW two-cycle issue.
// Optional HAZARD_PERF_CNT_EN adds load-use and DW2 cycle counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int OPC_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  opcode_d,
  input  logic [REG_W-1:0]  rd_d,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic              flush_d,
  input  logic [REG_W-1:0]  rd_ex,
  input  logic              regwr_ex,
  input  logic              memrd_ex,
  input  logic [REG_W-1:0]  rd_mem,
  input  logic              regwr_mem,
  input  logic [REG_W-1:0]  rd_wb,
  input  logic              regwr_wb,
  output logic              dw_phase,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              exception,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              bubble,
  output hazard_state_e     state_dbg
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       lu_stall_cnt,
  output logic [31:0]       dw_cycle_cnt
`endif
);

  hazard_state_e    state_q, state_d;
  logic [31:0]      op_w;
  logic             is_dw, idle, used_a, used_b;
  logic [REG_W-1:0] rd_eff, src_b;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             lu_raw, exc_raw, lu_act;

  assign op_w   = 32'(opcode_d);
  assign is_dw  = (op_w == OP_LDW) || (op_w == OP_SDW);
  assign idle   = (state_q == IDLE);
  // Second half of a double-word op addresses the odd partner register.
  assign rd_eff = idle ? rd_d : rd_d + REG_W'(1);
  assign used_a = uses_src_a(op_w);
  assign used_b = uses_src_b(op_w);
  assign src_b  = (op_w <= OP_SUB) ? rt_d : rd_eff;

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src(rs_d), .used(used_a),
    .rd_ex(rd_ex), .regwr_ex(regwr_ex),
    .rd_mem(rd_mem), .regwr_mem(regwr_mem),
    .rd_wb(rd_wb), .regwr_wb(regwr_wb),
    .fwd(fwd_a_raw)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src(src_b), .used(used_b),
    .rd_ex(rd_ex), .regwr_ex(regwr_ex),
    .rd_mem(rd_mem), .regwr_mem(regwr_mem),
    .rd_wb(rd_wb), .regwr_wb(regwr_wb),
    .fwd(fwd_b_raw)
  );

  assign lu_raw  = memrd_ex && regwr_ex && (rd_ex != '0) &&
                   ((used_a && (rd_ex == rs_d)) || (used_b && (rd_ex == src_b)));
  assign exc_raw = idle && is_dw && rd_d[0];
  assign lu_act  = !reset && !flush_d && !exc_raw && lu_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Priority chain: reset, flush, exception, load-use, double-word sequencing.
  always_comb begin
    state_d   = IDLE;
    dw_phase  = 1'b0;
    forward_a = FWD_RF;
    forward_b = FWD_RF;
    exception = 1'b0;
    pc_hold   = 1'b0;
    ifid_hold = 1'b0;
    bubble    = 1'b0;
    state_dbg = IDLE;
    if (!reset) begin
      state_dbg = state_q;
      dw_phase  = !idle;
      forward_a = fwd_a_raw;
      forward_b = fwd_b_raw;
      if (flush_d) begin
        bubble = 1'b1;
      end else if (exc_raw) begin
        exception = 1'b1;
        bubble    = 1'b1;
      end else if (lu_act) begin
        bubble    = 1'b1;
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        state_d   = state_q;
      end else if (idle && is_dw) begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        state_d   = DW2;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_stall_cnt <= '0;
      dw_cycle_cnt <= '0;
    end else begin
      if (lu_act)          lu_stall_cnt <= lu_stall_cnt + 32'd1;
      if (state_q == DW2)  dw_cycle_cnt <= dw_cycle_cnt + 32'd1;
    end
  end
`endif

endmodule
